// File: rtl/fas_fft_frame_reader.sv
// Reader for the FAS FFT result bus: captures 16-bin frames into a ping-pong buffer and
// streams them out one bin per cycle with per-frame peak-magnitude index and drop accounting.
module fas_fft_frame_reader #(
    parameter int unsigned OUT_ORDER = 0,
    parameter int unsigned DROP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  logic [31:0]       fft_d0,
    input  logic [31:0]       fft_d1,
    input  logic [31:0]       fft_d2,
    input  logic [31:0]       fft_d3,
    input  logic [31:0]       fft_d4,
    input  logic [31:0]       fft_d5,
    input  logic [31:0]       fft_d6,
    input  logic [31:0]       fft_d7,
    input  logic [31:0]       fft_d8,
    input  logic [31:0]       fft_d9,
    input  logic [31:0]       fft_d10,
    input  logic [31:0]       fft_d11,
    input  logic [31:0]       fft_d12,
    input  logic [31:0]       fft_d13,
    input  logic [31:0]       fft_d14,
    input  logic [31:0]       fft_d15,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic [3:0]        out_peak,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [DROP_W-1:0] drop_cnt
);

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // 17-bit result so that |-32768| stays representable.
    function automatic logic [16:0] abs17(input logic [15:0] v);
        logic [16:0] s;
        s = {v[15], v};
        return v[15] ? (~s + 17'd1) : s;
    endfunction

    logic [15:0][31:0] fft_frame;
    assign fft_frame = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                        fft_d7, fft_d6, fft_d5, fft_d4, fft_d3, fft_d2, fft_d1, fft_d0};

    logic [15:0][31:0] bank_q [2];
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [3:0]        pos_q, pos_d;
    logic [16:0]       peak_mag_q, peak_mag_d;
    logic [3:0]        peak_idx_q, peak_idx_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        valid;
    logic [3:0]  rd_idx;
    logic [31:0] rd_word;
    logic [16:0] cur_mag;
    logic        mag_gt;
    logic        hs, last_hs, wr_free, capture, drop;

    always_comb begin
        valid   = full_q[rd_bank_q];
        rd_idx  = (OUT_ORDER != 0) ? bitrev4(pos_q) : pos_q;
        rd_word = bank_q[rd_bank_q][rd_idx];
        cur_mag = abs17(rd_word[31:16]) + abs17(rd_word[15:0]);
        mag_gt  = cur_mag > peak_mag_q;
        hs      = valid & out_ready;
        last_hs = hs & (pos_q == 4'd15);
        // A bank being drained on this very edge can take the incoming frame.
        wr_free = ~full_q[wr_bank_q] | (last_hs & (rd_bank_q == wr_bank_q));
        capture = fft_valid & wr_free;
        drop    = fft_valid & ~wr_free;
    end

    always_comb begin
        full_d = full_q;
        if (last_hs) full_d[rd_bank_q] = 1'b0;
        if (capture) full_d[wr_bank_q] = 1'b1;
        wr_bank_d = wr_bank_q ^ capture;
        rd_bank_d = rd_bank_q ^ last_hs;
        pos_d     = hs ? pos_q + 4'd1 : pos_q;

        peak_mag_d = peak_mag_q;
        peak_idx_d = peak_idx_q;
        if (last_hs) begin
            peak_mag_d = '0;
            peak_idx_d = '0;
        end else if (hs && mag_gt) begin
            peak_mag_d = cur_mag;
            peak_idx_d = rd_idx;
        end

        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            pos_q      <= '0;
            peak_mag_q <= '0;
            peak_idx_q <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            pos_q      <= pos_d;
            peak_mag_q <= peak_mag_d;
            peak_idx_q <= peak_idx_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Bank contents need no reset: the full flags gate everything that reaches the outputs.
    always_ff @(posedge clk) begin
        if (capture) bank_q[wr_bank_q] <= fft_frame;
    end

    always_comb begin
        out_valid = valid;
        out_idx   = rd_idx;
        out_data  = valid ? rd_word : 32'd0;
        out_last  = valid & (pos_q == 4'd15);
        out_peak  = valid ? (mag_gt ? rd_idx : peak_idx_q) : 4'd0;
        ovf       = ovf_q;
        drop_cnt  = drop_cnt_q;
    end

endmodule
